// File: rtl/hamming_err_inj_pkg.sv
// Shared types, widths and helpers for the Hamming pattern generator / error injector.
package hamming_err_inj_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned PAR_W  = 8;
  localparam int unsigned CW_W   = 72;
  localparam int unsigned POS_W  = 7;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned DIDX_W = $clog2(DATA_W);
  localparam int unsigned PIDX_W = $clog2(PAR_W);

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CW_W-1:0]   pattern_t;
  typedef logic [PAR_W-1:0]  parity_t;
  typedef logic [POS_W-1:0]  pos_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_SINGLE = 2'd1,
    ERR_DOUBLE = 2'd2,
    ERR_ALT    = 2'd3
  } err_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Burst configuration captured when a start is accepted
  typedef struct packed {
    logic [CNT_W-1:0] remaining;
    err_mode_e        mode;
    pos_t             pos0;
    pos_t             pos1;
  } cfg_t;

  // True for 1-based codeword positions that hold a Hamming parity bit
  function automatic logic HAM_IS_PARITY_POS(input int unsigned pos);
    return (pos inside {1, 2, 4, 8, 16, 32, 64});
  endfunction

endpackage

// File: rtl/hamming_err_inj_if.sv
// Codeword stream towards the Hamming detection/correction stage.
interface hamming_err_inj_if;
  import hamming_err_inj_pkg::*;

  pattern_t o_pattern;
  pattern_t o_golden;
  logic     o_valid;

  modport master (output o_pattern, output o_golden, output o_valid);
  modport slave  (input  o_pattern, input  o_golden, input  o_valid);

endinterface

// File: rtl/hamming_err_inj_enc.sv
// Combinational Hamming(71,64) SEC encoder plus overall parity at bit 71 (SEC-DED).
module hamming_enc
  import hamming_err_inj_pkg::*;
(
  input  data_t    data,
  output pattern_t codeword
);

  pattern_t placed;
  parity_t  par;

  // Scatter data bits into the non-power-of-two positions, ascending
  always_comb begin
    int unsigned k;
    placed = '0;
    k      = 0;
    for (int unsigned pos = 1; pos < CW_W; pos++) begin
      if (!HAM_IS_PARITY_POS(pos)) begin
        placed[POS_W'(pos - 1)] = data[DIDX_W'(k)];
        k++;
      end
    end
  end

  // Parity bit b covers every position whose 1-based index has bit b set
  always_comb begin
    par      = '0;
    codeword = placed;
    for (int unsigned b = 0; b < PAR_W - 1; b++) begin
      for (int unsigned pos = 1; pos < CW_W; pos++) begin
        if (((pos >> b) & 32'd1) != 32'd0) begin
          par[PIDX_W'(b)] = par[PIDX_W'(b)] ^ placed[POS_W'(pos - 1)];
        end
      end
      codeword[POS_W'((32'd1 << b) - 32'd1)] = par[PIDX_W'(b)];
    end
    par[PAR_W-1]       = ^codeword[CW_W-2:0];
    codeword[CW_W-1]   = par[PAR_W-1];
  end

endmodule

// File: rtl/hamming_err_inj.sv
// LFSR pattern generator that encodes each word to SEC-DED and injects 0/1/2 bit flips.
module hamming_err_inj
  import hamming_err_inj_pkg::*;
#(
  parameter data_t LFSR_SEED = 64'h0000_0000_0000_0001
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_count,
  input  logic [1:0]       i_err_mode,
  input  pos_t             i_err_pos0,
  input  pos_t             i_err_pos1,
  hamming_err_inj_if.master bus,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_sent
);

  // An all-zero LFSR would lock up, so a zero seed becomes 1
  localparam data_t SEED = (LFSR_SEED == '0) ? data_t'(1) : LFSR_SEED;

  state_e   state;
  data_t    lfsr;
  cfg_t     cfg;
  pattern_t golden_c;
  pattern_t mask_c;
  pos_t     p0_c;
  pos_t     p1_c;
  logic     lfsr_fb_c;

  hamming_enc u_enc (
    .data     (lfsr),
    .codeword (golden_c)
  );

  assign lfsr_fb_c = lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59];

  function automatic pos_t reduce_pos(input pos_t p);
    return (p >= POS_W'(CW_W)) ? p - POS_W'(CW_W) : p;
  endfunction

  // Error mask; a colliding second position is nudged so two bits always flip
  always_comb begin
    p0_c = reduce_pos(cfg.pos0);
    p1_c = reduce_pos(cfg.pos1);
    if (p1_c == p0_c) begin
      p1_c = (p0_c == POS_W'(CW_W - 1)) ? '0 : p0_c + 1'b1;
    end
    case (cfg.mode)
      ERR_SINGLE: mask_c = pattern_t'(1) << p0_c;
      ERR_DOUBLE: mask_c = (pattern_t'(1) << p0_c) | (pattern_t'(1) << p1_c);
      ERR_ALT:    mask_c = o_sent[0] ? ((pattern_t'(1) << p0_c) | (pattern_t'(1) << p1_c))
                                     : (pattern_t'(1) << p0_c);
      default:    mask_c = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state         <= ST_IDLE;
      lfsr          <= SEED;
      cfg           <= '0;
      bus.o_pattern <= '0;
      bus.o_golden  <= '0;
      bus.o_valid   <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_sent        <= '0;
    end else begin
      bus.o_valid <= 1'b0;
      o_done      <= 1'b0;
      o_busy      <= (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (i_en && i_start) begin
            cfg    <= '{remaining: i_count, mode: err_mode_e'(i_err_mode),
                        pos0: i_err_pos0, pos1: i_err_pos1};
            o_sent <= '0;
            o_busy <= 1'b1;
            state  <= (i_count == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (i_en) begin
            bus.o_golden  <= golden_c;
            bus.o_pattern <= golden_c ^ mask_c;
            bus.o_valid   <= 1'b1;
            lfsr          <= {lfsr[DATA_W-2:0], lfsr_fb_c};
            cfg.remaining <= cfg.remaining - 1'b1;
            o_sent        <= o_sent + 1'b1;
            if (cfg.remaining == CNT_W'(1)) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          o_done <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_err_inj.sv
// Scoreboard bench for hamming_err_inj: directed bursts with hand-computed codewords and masks.
module tb_hamming_err_inj;
  import hamming_err_inj_pkg::*;

  typedef struct packed {
    pattern_t pattern;
    pattern_t golden;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic        start = 1'b0;
  logic [15:0] count = '0;
  logic [1:0]  mode  = '0;
  pos_t        pos0  = '0;
  pos_t        pos1  = '0;
  logic        busy;
  logic        done;
  logic [15:0] sent;

  int total = 0;
  int bad   = 0;
  exp_t     exp_q[$];
  pattern_t gold_tab [0:16];

  hamming_err_inj_if bus ();

  hamming_err_inj #(.LFSR_SEED(64'h1)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_start    (start),
    .i_count    (count),
    .i_err_mode (mode),
    .i_err_pos0 (pos0),
    .i_err_pos1 (pos1),
    .bus        (bus),
    .o_busy     (busy),
    .o_done     (done),
    .o_sent     (sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push(input int idx, input pattern_t mask);
    exp_t e;
    e.golden  = gold_tab[idx];
    e.pattern = gold_tab[idx] ^ mask;
    exp_q.push_back(e);
  endtask

  task automatic start_burst(input logic [15:0] c, input logic [1:0] m, input pos_t a, input pos_t b);
    start = 1'b1;
    count = c;
    mode  = m;
    pos0  = a;
    pos1  = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_cyc, input logic [15:0] exp_sent);
    int cyc  = 0;
    bit seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk({name, "_busy"}, 72'(busy), 72'(1));
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: o_done not seen within %0d cycles", name, cyc);
    end else begin
      chk({name, "_done_latency"}, 72'(cyc), 72'(exp_cyc));
    end
    @(posedge clk); #1;
    chk({name, "_sent"}, 72'(sent), 72'(exp_sent));
    chk({name, "_busy_off"}, 72'(busy), 72'(0));
    chk({name, "_queue_empty"}, 72'(exp_q.size()), 72'(0));
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_pattern"}, bus.o_pattern, 72'(0));
    chk({name, "_golden"}, bus.o_golden, 72'(0));
    chk({name, "_valid"}, 72'(bus.o_valid), 72'(0));
    chk({name, "_busy"}, 72'(busy), 72'(0));
    chk({name, "_done"}, 72'(done), 72'(0));
    chk({name, "_sent"}, 72'(sent), 72'(0));
  endtask

  // Monitor: every valid word is checked against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.o_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got pattern %h with nothing expected", bus.o_pattern);
        end else begin
          e = exp_q.pop_front();
          chk("word_golden", bus.o_golden, e.golden);
          chk("word_pattern", bus.o_pattern, e.pattern);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Codewords of data = 1<<k for k = 0..16 (the LFSR walks a single one from seed 1)
    gold_tab = '{
      72'h80_0000_0000_0000_0007, 72'h80_0000_0000_0000_0019,
      72'h80_0000_0000_0000_002A, 72'h00_0000_0000_0000_004B,
      72'h80_0000_0000_0000_0181, 72'h80_0000_0000_0000_0282,
      72'h00_0000_0000_0000_0483, 72'h80_0000_0000_0000_0888,
      72'h00_0000_0000_0000_1089, 72'h00_0000_0000_0000_208A,
      72'h80_0000_0000_0000_408B, 72'h80_0000_0000_0001_8001,
      72'h80_0000_0000_0002_8002, 72'h00_0000_0000_0004_8003,
      72'h80_0000_0000_0008_8008, 72'h00_0000_0000_0010_8009,
      72'h00_0000_0000_0020_800A
    };

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    en    = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) push(i, '0);
    start_burst(16'd4, 2'd0, 7'd0, 7'd0);
    wait_done("mode0", 6, 16'd4);

    for (int i = 4; i < 7; i++) push(i, 72'h20);
    start_burst(16'd3, 2'd1, 7'd5, 7'd40);
    wait_done("single", 5, 16'd3);

    // Double at 71/71 wraps the second flip to bit 0; a start during RUN is ignored
    push(7, 72'h80_0000_0000_0000_0001);
    push(8, 72'h80_0000_0000_0000_0001);
    start_burst(16'd2, 2'd2, 7'd71, 7'd71);
    start = 1'b1;
    count = 16'd5;
    mode  = 2'd0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ignored_start", 3, 16'd2);

    push(9, 72'h108);
    start_burst(16'd1, 2'd2, 7'd80, 7'd3);
    wait_done("pos_wrap", 3, 16'd1);
    push(10, 72'h108);
    start_burst(16'd1, 2'd2, 7'd8, 7'd3);
    wait_done("pos_plain", 3, 16'd1);

    // Alternate mode with a 3-cycle enable stall after word 2
    push(11, 72'h4);
    push(12, 72'h204);
    push(13, 72'h4);
    push(14, 72'h204);
    start_burst(16'd4, 2'd3, 7'd2, 7'd9);
    @(posedge clk);
    @(posedge clk); #1;
    en = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_valid", 72'(bus.o_valid), 72'(0));
    end
    chk("stall_sent", 72'(sent), 72'(2));
    en = 1'b1;
    wait_done("alt_stall", 3, 16'd4);

    start_burst(16'd0, 2'd1, 7'd5, 7'd5);
    wait_done("zero_count", 2, 16'd0);

    // Reset in the middle of a 10-word burst, then restart from the seed
    push(15, '0);
    push(16, '0);
    start_burst(16'd10, 2'd0, 7'd0, 7'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_zero("mid_reset");
    chk("mid_reset_queue", 72'(exp_q.size()), 72'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    push(0, '0);
    push(1, '0);
    start_burst(16'd2, 2'd0, 7'd0, 7'd0);
    wait_done("reseed", 4, 16'd2);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
